formula_sqrt_tb: RTL and testbench

FORMULA_SQRT_TB -- requirements
Module: formula_sqrt_tb

---
 rtl/formula_sqrt_tb_pkg.sv | 13 +
 rtl/formula_sqrt_tb_if.sv | 16 +
 rtl/formula_sqrt_tb_isqrt_seq.sv | 91 +++++++++
 rtl/formula_sqrt_tb.sv | 138 +++++++++++++
 tb/tb_formula_sqrt_tb.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/formula_sqrt_tb_pkg.sv
// rtl/formula_sqrt_tb_pkg.sv - shared widths, latency and FSM state type
package formula_sqrt_tb_pkg;

  localparam int OPND_W    = 32;
  localparam int ROOT_W    = 16;
  localparam int ISQRT_LAT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/formula_sqrt_tb_if.sv
// rtl/formula_sqrt_tb_if.sv - operand/result bus of the sqrt formula block
// arg_vld/a/b/c : operands, qualified by arg_vld for one cycle
// res_vld/res   : result, res_vld is a single-cycle pulse
interface formula_sqrt_tb_if;

  logic        arg_vld;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic        res_vld;
  logic [31:0] res;

  modport master (output arg_vld, a, b, c, input res_vld, res);
  modport slave  (input arg_vld, a, b, c, output res_vld, res);

endinterface

// File: rtl/formula_sqrt_tb_isqrt_seq.sv
// rtl/formula_sqrt_tb_isqrt_seq.sv - restoring bit-serial integer square root
// clk, rst_n : clock, asynchronous active-low reset
// x_vld, x   : start strobe and 32-bit radicand
// y_vld, y   : done strobe (16 cycles after x_vld) and 16-bit floor root
module isqrt_seq
  import formula_sqrt_tb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              x_vld,
  input  logic [OPND_W-1:0] x,
  output logic              y_vld,
  output logic [ROOT_W-1:0] y
);

  localparam int CNT_W = $clog2(ISQRT_LAT);

  logic [OPND_W-1:0] xs_q, xs_d;
  logic [ROOT_W+1:0] rem_q, rem_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              y_vld_q, y_vld_d;

  logic [OPND_W-1:0] src_xs;
  logic [ROOT_W+1:0] src_rem;
  logic [ROOT_W-1:0] src_root;
  logic [ROOT_W+3:0] rem_t;
  logic [ROOT_W+3:0] trial;

  always_comb begin
    // The start cycle already performs the first step on the raw input,
    // so 16 steps finish in time for done 16 cycles after start.
    src_xs   = x_vld ? x  : xs_q;
    src_rem  = x_vld ? '0 : rem_q;
    src_root = x_vld ? '0 : root_q;
    rem_t    = {src_rem, src_xs[OPND_W-1 -: 2]};
    trial    = {2'b00, src_root, 2'b01};

    xs_d    = xs_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    y_vld_d = 1'b0;

    if (x_vld || busy_q) begin
      xs_d = {src_xs[OPND_W-3:0], 2'b00};
      if (rem_t >= trial) begin
        // Remainder stays below 2^17, so the low-bit difference is exact.
        rem_d  = rem_t[ROOT_W+1:0] - trial[ROOT_W+1:0];
        root_d = {src_root[ROOT_W-2:0], 1'b1};
      end else begin
        rem_d  = rem_t[ROOT_W+1:0];
        root_d = {src_root[ROOT_W-2:0], 1'b0};
      end
      if (x_vld) begin
        busy_d = 1'b1;
        cnt_d  = CNT_W'(1);
      end else if (cnt_q == CNT_W'(ISQRT_LAT - 1)) begin
        busy_d  = 1'b0;
        y_vld_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs_q    <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      y_vld_q <= 1'b0;
    end else begin
      xs_q    <= xs_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      y_vld_q <= y_vld_d;
    end
  end

  assign y_vld = y_vld_q;
  assign y     = root_q;

endmodule

// File: rtl/formula_sqrt_tb.sv
// rtl/formula_sqrt_tb.sv - sum or nested isqrt formula over three operands
// clk, rst_n : clock, asynchronous active-low reset
// bus        : slave side of formula_sqrt_tb_if (arg_vld/a/b/c in, res_vld/res out)
// FORMULA 1 : isqrt(a)+isqrt(b)+isqrt(c); 2 : isqrt(a+isqrt(b+isqrt(c)))
// IMPL    1 : one shared isqrt sequenced over three phases; 2 : three in parallel
module formula_sqrt_tb
  import formula_sqrt_tb_pkg::*;
#(
  parameter int FORMULA = 1,
  parameter int IMPL    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  formula_sqrt_tb_if.slave  bus
);

  localparam bit PAR = (FORMULA == 1) && (IMPL == 2);

  state_t            state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic              start_q, start_d;
  logic [OPND_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [OPND_W-1:0] acc_q, acc_d, res_q, res_d;

  logic              root_vld;
  logic [OPND_W-1:0] root_sum;
  logic [OPND_W-1:0] done_val;
  logic              last;
  logic              res_vld;

  generate
    if (PAR) begin : g_par
      logic [2:0]        v;
      logic [ROOT_W-1:0] y0, y1, y2;
      isqrt_seq u_sqrt0 (.clk(clk), .rst_n(rst_n), .x_vld(start_q), .x(a_q), .y_vld(v[0]), .y(y0));
      isqrt_seq u_sqrt1 (.clk(clk), .rst_n(rst_n), .x_vld(start_q), .x(b_q), .y_vld(v[1]), .y(y1));
      isqrt_seq u_sqrt2 (.clk(clk), .rst_n(rst_n), .x_vld(start_q), .x(c_q), .y_vld(v[2]), .y(y2));
      assign root_vld = &v;
      assign root_sum = {16'b0, y0} + {16'b0, y1} + {16'b0, y2};
      assign last     = 1'b1;
    end else begin : g_seq
      logic              v;
      logic [ROOT_W-1:0] y;
      logic [OPND_W-1:0] x_sel;
      // Phase picks the radicand; for the nested form acc_q holds the previous root.
      always_comb begin
        x_sel = '0;
        if (FORMULA == 1) begin
          case (phase_q)
            2'd0:    x_sel = a_q;
            2'd1:    x_sel = b_q;
            2'd2:    x_sel = c_q;
            default: x_sel = '0;
          endcase
        end else begin
          case (phase_q)
            2'd0:    x_sel = c_q;
            2'd1:    x_sel = b_q + acc_q;
            2'd2:    x_sel = a_q + acc_q;
            default: x_sel = '0;
          endcase
        end
      end
      isqrt_seq u_sqrt (.clk(clk), .rst_n(rst_n), .x_vld(start_q), .x(x_sel), .y_vld(v), .y(y));
      assign root_vld = v;
      assign root_sum = {16'b0, y};
      assign last     = (phase_q == 2'd2);
    end
  endgenerate

  assign done_val = (FORMULA == 1) ? acc_q + root_sum : root_sum;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    start_d = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    res_d   = res_q;
    res_vld = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.arg_vld) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.c;
          acc_d   = '0;
          phase_d = 2'd0;
          start_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (root_vld) begin
          if (last) begin
            res_vld = 1'b1;
            res_d   = done_val;
            state_d = IDLE;
          end else begin
            acc_d   = done_val;
            phase_d = phase_q + 2'd1;
            start_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= 2'd0;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  // The final result is presented in the done cycle itself and held afterwards.
  assign bus.res_vld = res_vld;
  assign bus.res     = res_vld ? done_val : res_q;

endmodule

// File: tb/tb_formula_sqrt_tb.sv
// tb/tb_formula_sqrt_tb.sv - directed and random checks of all three configurations
module tb_formula_sqrt_tb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        av [3];
  logic [31:0] aa [3];
  logic [31:0] bb [3];
  logic [31:0] cc [3];
  logic        rv [3];
  logic [31:0] rr [3];
  int          cnt   [3] = '{0, 0, 0};
  int          nruns [3] = '{0, 0, 0};
  int          c0s   [3];
  int          ncmp = 0;
  int          nfail = 0;

  formula_sqrt_tb_if bus0 ();
  formula_sqrt_tb_if bus1 ();
  formula_sqrt_tb_if bus2 ();

  assign bus0.arg_vld = av[0];
  assign bus0.a = aa[0];
  assign bus0.b = bb[0];
  assign bus0.c = cc[0];
  assign bus1.arg_vld = av[1];
  assign bus1.a = aa[1];
  assign bus1.b = bb[1];
  assign bus1.c = cc[1];
  assign bus2.arg_vld = av[2];
  assign bus2.a = aa[2];
  assign bus2.b = bb[2];
  assign bus2.c = cc[2];
  assign rv[0] = bus0.res_vld;
  assign rr[0] = bus0.res;
  assign rv[1] = bus1.res_vld;
  assign rr[1] = bus1.res;
  assign rv[2] = bus2.res_vld;
  assign rr[2] = bus2.res;

  formula_sqrt_tb #(.FORMULA(1), .IMPL(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  formula_sqrt_tb #(.FORMULA(1), .IMPL(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  formula_sqrt_tb #(.FORMULA(2), .IMPL(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // Pulses of the cycle just ended are counted at its closing edge.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) if (rv[k] === 1'b1) cnt[k]++;
  end

  function automatic logic [31:0] isq(input logic [31:0] x);
    longint unsigned r = 0;
    longint unsigned t;
    for (int bn = 15; bn >= 0; bn--) begin
      t = r | (64'd1 << bn);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] model(input int k, input logic [31:0] a, b, c);
    logic [31:0] s1, s2;
    if (k == 2) begin
      s1 = isq(c);
      s2 = isq(b + s1);
      return isq(a + s2);
    end
    return isq(a) + isq(b) + isq(c);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int k, input logic [31:0] a, b, c, input logic [31:0] exp,
                     input int lat, input bit nowait, input bit dup);
    int c0;
    int t0;
    int dt;
    bit found;
    if (!nowait) @(negedge clk);
    c0 = cnt[k];
    av[k] = 1'b1;
    aa[k] = a;
    bb[k] = b;
    cc[k] = c;
    @(negedge clk);
    av[k] = 1'b0;
    t0 = cyc;
    found = 1'b0;
    dt = 0;
    for (int i = 0; i < 200; i++) begin
      dt = cyc - t0 + 1;
      if (dup && dt == 5) begin
        av[k] = 1'b1;
        aa[k] = 32'hFFFF_FFFF;
        bb[k] = 32'd1;
        cc[k] = 32'd7;
      end else begin
        av[k] = 1'b0;
      end
      if (rv[k] === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    av[k] = 1'b0;
    nruns[k]++;
    check($sformatf("dut%0d res_vld_seen", k), 32'(found), 32'd1);
    check($sformatf("dut%0d res a=%0d b=%0d c=%0d", k, a, b, c), rr[k], exp);
    check($sformatf("dut%0d latency", k), 32'(dt), 32'(lat));
    check($sformatf("dut%0d single_pulse", k), 32'(cnt[k]), 32'(c0));
  endtask

  initial begin
    logic [31:0] ra, rb, rc;
    for (int k = 0; k < 3; k++) begin
      av[k] = 1'b0;
      aa[k] = '0;
      bb[k] = '0;
      cc[k] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("dut%0d reset res_vld", k), 32'(rv[k]), 32'd0);
      check($sformatf("dut%0d reset res", k), rr[k], 32'd0);
    end

    // First arg_vld accepted on the first edge after reset release
    rst_n = 1'b1;
    run(0, 32'd16, 32'd81, 32'd100, 32'd23, 51, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("dut0 res_hold", rr[0], 32'd23);
    run(1, 32'd16, 32'd81, 32'd100, 32'd23, 17, 1'b0, 1'b0);
    run(2, 32'd16, 32'd9,  32'd49,  32'd4,  51, 1'b0, 1'b0);

    // Extremes, including wraparound of the nested additions
    run(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd196605, 51, 1'b0, 1'b0);
    run(0, 32'd0, 32'd0, 32'd0, 32'd0, 51, 1'b0, 1'b0);
    run(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd196605, 17, 1'b0, 1'b0);
    run(1, 32'd0, 32'd0, 32'd0, 32'd0, 17, 1'b0, 1'b0);
    run(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd15, 51, 1'b0, 1'b0);
    run(2, 32'd0, 32'd0, 32'd0, 32'd0, 51, 1'b0, 1'b0);

    // arg_vld while busy is ignored
    run(0, 32'd16, 32'd81, 32'd100, 32'd23, 51, 1'b0, 1'b1);
    run(1, 32'd16, 32'd81, 32'd100, 32'd23, 17, 1'b0, 1'b1);
    run(2, 32'd16, 32'd9,  32'd49,  32'd4,  51, 1'b0, 1'b1);

    // Reset mid-computation aborts without a result
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      av[k] = 1'b1;
      aa[k] = 32'd16;
      bb[k] = (k == 2) ? 32'd9 : 32'd81;
      cc[k] = (k == 2) ? 32'd49 : 32'd100;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) av[k] = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("dut%0d abort res_vld", k), 32'(rv[k]), 32'd0);
      check($sformatf("dut%0d abort res", k), rr[k], 32'd0);
      c0s[k] = cnt[k];
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("dut%0d abort no_pulse", k), 32'(cnt[k]), 32'(c0s[k]));
    run(0, 32'd1, 32'd4, 32'd9, 32'd6, 51, 1'b0, 1'b0);
    run(1, 32'd1000000, 32'd65536, 32'd2, 32'd1257, 17, 1'b0, 1'b0);
    run(2, 32'd100, 32'd5, 32'd16, 32'd10, 51, 1'b0, 1'b0);

    // Random operands, each set issued on the cycle after the previous result
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 100; i++) begin
        if (i % 3 == 0) begin
          ra = $urandom_range(0, 70000);
          rb = $urandom_range(0, 70000);
          rc = $urandom_range(0, 70000);
        end else begin
          ra = $urandom;
          rb = $urandom;
          rc = $urandom;
        end
        run(k, ra, rb, rc, model(k, ra, rb, rc), (k == 1) ? 17 : 51, 1'b0, 1'b0);
      end
    end

    // Exactly one pulse per accepted operand set overall
    repeat (60) @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("dut%0d total_pulses", k), 32'(cnt[k]), 32'(nruns[k]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
